vecmac_result_collector: RTL and testbench

//  Downstream end of the mul16x8x8_wallace result interface. It samples out_valid/out_sum,

---
 rtl/vecmac_result_collector_pkg.sv | 34 +++
 rtl/vecmac_result_collector_fifo.sv | 65 ++++++
 rtl/vecmac_result_collector.sv | 161 ++++++++++++++++
 tb/tb_vecmac_result_collector.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vecmac_result_collector_pkg.sv
// Shared constants, types and helpers for the vecmac result collector.
// Widths match the 16-lane 8x8 MAC that feeds this block.
package vecmac_result_collector_pkg;

    localparam int LANES      = 16;
    localparam int SUM_W      = 20;
    localparam int ACC_W      = 32;
    localparam int MAC_LAT    = 3;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 16;

    localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
    localparam int RES_W  = ACC_W + CNT_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } acc_state_t;

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic [CNT_W-1:0] beats;
        logic             ovf;
    } result_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [ACC_W-1:0] zext_sum(input logic [SUM_W-1:0] v);
        return {{(ACC_W - SUM_W){1'b0}}, v};
    endfunction

endpackage

// File: rtl/vecmac_result_collector_fifo.sv
// Show-ahead synchronous FIFO for completed segment results.
// Head entry is visible on pop_data whenever empty=0; a push into a full FIFO without a pop is dropped.
module vecmac_result_collector_fifo #(
    parameter int WIDTH = 49,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             ovrun
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        ovrun    = push && full && !pop_ok;
        pop_data = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/vecmac_result_collector.sv
// Collects MAC dot-product beats into segment sums and queues finished segments.
// Upstream is throttled by issue_ok credits so a queued result is never overwritten.
module vecmac_result_collector
    import vecmac_result_collector_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_valid,
    input  logic             iss_last,
    output logic             issue_ok,
    input  logic             mac_valid,
    input  logic [SUM_W-1:0] mac_sum,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ACC_W-1:0] m_sum,
    output logic [CNT_W-1:0] m_beats,
    output logic             m_ovf,
    output logic             err_align,
    output logic             err_ovrun
);

    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(FIFO_DEPTH);

    logic [MAC_LAT-1:0] dl_valid_q, dl_valid_d;
    logic [MAC_LAT-1:0] dl_last_q, dl_last_d;
    logic               tap_valid;
    logic               tap_last;

    logic [CRED_W-1:0]  credits_q, credits_d;
    logic               err_align_q, err_align_d;
    logic               err_ovrun_q, err_ovrun_d;

    acc_state_t         state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   beats_q, beats_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W:0]     sum_ext;
    logic               push;
    result_t            push_res;
    result_t            head_res;
    logic [RES_W-1:0]   head_bits;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_ovrun;
    logic               pop_fire;

    // Issue-side strobes shifted to line up with mac_valid.
    always_comb begin
        dl_valid_d = (dl_valid_q << 1) | MAC_LAT'(iss_valid);
        dl_last_d  = (dl_last_q << 1) | MAC_LAT'(iss_valid & iss_last);
        tap_valid  = dl_valid_q[MAC_LAT-1];
        tap_last   = dl_last_q[MAC_LAT-1];
    end

    always_comb begin
        pop_fire  = !fifo_empty && m_ready;
        credits_d = credits_q;
        if ((iss_valid && iss_last) && !pop_fire) begin
            credits_d = (credits_q == '0) ? '0 : credits_q - CRED_W'(1);
        end else if (pop_fire && !(iss_valid && iss_last)) begin
            credits_d = (credits_q == CRED_MAX) ? CRED_MAX : credits_q + CRED_W'(1);
        end
        err_align_d = err_align_q | (mac_valid != tap_valid);
        err_ovrun_d = err_ovrun_q | fifo_ovrun;
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            beats_q     <= '0;
            ovf_q       <= 1'b0;
            dl_valid_q  <= '0;
            dl_last_q   <= '0;
            credits_q   <= CRED_MAX;
            err_align_q <= 1'b0;
            err_ovrun_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            beats_q     <= beats_d;
            ovf_q       <= ovf_d;
            dl_valid_q  <= dl_valid_d;
            dl_last_q   <= dl_last_d;
            credits_q   <= credits_d;
            err_align_q <= err_align_d;
            err_ovrun_q <= err_ovrun_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        if (mac_valid) begin
            state_d = tap_last ? ST_IDLE : ST_ACC;
        end
    end

    // FSM: datapath and push generation.
    always_comb begin
        acc_d    = acc_q;
        beats_d  = beats_q;
        ovf_d    = ovf_q;
        push     = 1'b0;
        push_res = '0;
        sum_ext  = {1'b0, acc_q} + {1'b0, zext_sum(mac_sum)};
        if (mac_valid) begin
            case (state_q)
                ST_IDLE: begin
                    acc_d   = zext_sum(mac_sum);
                    beats_d = CNT_W'(1);
                    ovf_d   = 1'b0;
                end
                ST_ACC: begin
                    acc_d   = sum_ext[ACC_W-1:0];
                    beats_d = sat_inc(beats_q);
                    ovf_d   = ovf_q | sum_ext[ACC_W];
                end
                default: begin
                    acc_d   = acc_q;
                end
            endcase
            if (tap_last) begin
                push           = 1'b1;
                push_res.sum   = acc_d;
                push_res.beats = beats_d;
                push_res.ovf   = ovf_d;
            end
        end
    end

    vecmac_result_collector_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_res),
        .pop       (m_ready),
        .pop_data  (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .ovrun     (fifo_ovrun)
    );

    // Payload is forced to zero while nothing is offered so stale entries never leak out.
    always_comb begin
        head_res  = result_t'(head_bits);
        m_valid   = !fifo_empty;
        m_sum     = m_valid ? head_res.sum : '0;
        m_beats   = m_valid ? head_res.beats : '0;
        m_ovf     = m_valid & head_res.ovf;
        issue_ok  = (credits_q != '0);
        err_align = err_align_q;
        err_ovrun = err_ovrun_q;
    end

endmodule

// File: tb/tb_vecmac_result_collector.sv
// Directed bench for vecmac_result_collector; a small MAC-latency model feeds mac_valid/mac_sum.
module tb_vecmac_result_collector;
    import vecmac_result_collector_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             iss_valid;
    logic             iss_last;
    logic             issue_ok;
    logic             mac_valid;
    logic [SUM_W-1:0] mac_sum;
    logic             m_valid;
    logic             m_ready;
    logic [ACC_W-1:0] m_sum;
    logic [CNT_W-1:0] m_beats;
    logic             m_ovf;
    logic             err_align;
    logic             err_ovrun;

    int total;
    int bad;

    logic             pv [MAC_LAT];
    logic [SUM_W-1:0] ps [MAC_LAT];

    vecmac_result_collector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_last  (iss_last),
        .issue_ok  (issue_ok),
        .mac_valid (mac_valid),
        .mac_sum   (mac_sum),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_sum     (m_sum),
        .m_beats   (m_beats),
        .m_ovf     (m_ovf),
        .err_align (err_align),
        .err_ovrun (err_ovrun)
    );

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock: inputs applied after a negedge, returns at the next negedge.
    task automatic cyc(input logic iv, input logic il, input logic [SUM_W-1:0] s,
                       input logic rdy, input logic inj, input logic [SUM_W-1:0] inj_s);
        mac_valid = inj ? 1'b1 : pv[MAC_LAT-1];
        mac_sum   = inj ? inj_s : ps[MAC_LAT-1];
        for (int i = MAC_LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            ps[i] = ps[i-1];
        end
        pv[0]     = iv;
        ps[0]     = s;
        iss_valid = iv;
        iss_last  = il;
        m_ready   = rdy;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic issue(input logic il, input logic [SUM_W-1:0] s);
        cyc(1'b1, il, s, 1'b0, 1'b0, '0);
    endtask

    task automatic pop_check(input string tag, input logic [ACC_W-1:0] s,
                             input logic [CNT_W-1:0] b, input logic o);
        check_val({tag, "_valid"}, 64'(m_valid), 64'd1);
        check_val({tag, "_sum"},   64'(m_sum),   64'(s));
        check_val({tag, "_beats"}, 64'(m_beats), 64'(b));
        check_val({tag, "_ovf"},   64'(m_ovf),   64'(o));
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < MAC_LAT; i++) begin
            pv[i] = 1'b0;
            ps[i] = '0;
        end
        idle(2);
        rst_n = 1'b1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        iss_valid = 1'b0;
        iss_last  = 1'b0;
        mac_valid = 1'b0;
        mac_sum   = '0;
        m_ready   = 1'b0;
        for (int i = 0; i < MAC_LAT; i++) begin
            pv[i] = 1'b0;
            ps[i] = '0;
        end
        @(negedge clk);
        do_reset();

        check_val("rst_m_valid",   64'(m_valid),   64'd0);
        check_val("rst_issue_ok",  64'(issue_ok),  64'd1);
        check_val("rst_m_sum",     64'(m_sum),     64'd0);
        check_val("rst_m_beats",   64'(m_beats),   64'd0);
        check_val("rst_err_align", 64'(err_align), 64'd0);
        check_val("rst_err_ovrun", 64'(err_ovrun), 64'd0);

        // single beat, latency MAC_LAT+1
        issue(1'b1, 20'd1040400);
        idle(2);
        check_val("t1_early", 64'(m_valid), 64'd0);
        idle(1);
        pop_check("t1", 32'd1040400, 16'd1, 1'b0);
        check_val("t1_empty", 64'(m_valid), 64'd0);

        // four-beat segment
        for (int i = 0; i < 4; i++) begin
            issue(i == 3, 20'd1040400);
            check_val("t2_issue_ok", 64'(issue_ok), 64'd1);
        end
        idle(3);
        pop_check("t2", 32'd4161600, 16'd4, 1'b0);

        // credit exhaustion and in-order drain
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, SUM_W'(1000 + i));
            check_val("t3_issue_ok", 64'(issue_ok), (i == 7) ? 64'd0 : 64'd1);
        end
        idle(3);
        check_val("t3_ovrun", 64'(err_ovrun), 64'd0);
        pop_check("t3_first", 32'd1000, 16'd1, 1'b0);
        check_val("t3_credit_back", 64'(issue_ok), 64'd1);
        for (int i = 1; i < 8; i++) begin
            pop_check("t3_drain", ACC_W'(1000 + i), 16'd1, 1'b0);
        end
        check_val("t3_empty", 64'(m_valid), 64'd0);
        check_val("t3_ovrun_end", 64'(err_ovrun), 64'd0);

        // accumulator wrap with carry-out
        for (int i = 0; i < 4200; i++) begin
            issue(i == 4199, 20'd1040400);
        end
        idle(3);
        pop_check("t4", 32'd74712704, 16'd4200, 1'b1);

        // stray mac_valid
        check_val("t5_pre", 64'(err_align), 64'd0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, 20'd5);
        check_val("t5_set", 64'(err_align), 64'd1);
        idle(4);
        check_val("t5_sticky", 64'(err_align), 64'd1);
        check_val("t5_no_push", 64'(m_valid), 64'd0);

        // stray beat (5) is still open, so the first segment absorbs it
        issue(1'b1, 20'd10);
        issue(1'b1, 20'd20);
        issue(1'b1, 20'd30);
        idle(3);
        check_val("t6_q_valid", 64'(m_valid), 64'd1);
        check_val("t6_q_sum",   64'(m_sum),   64'd15);
        check_val("t6_q_beats", 64'(m_beats), 64'd2);
        issue(1'b0, 20'd7);
        issue(1'b0, 20'd8);
        idle(3);
        do_reset();
        check_val("t6_m_valid",   64'(m_valid),   64'd0);
        check_val("t6_issue_ok",  64'(issue_ok),  64'd1);
        check_val("t6_m_sum",     64'(m_sum),     64'd0);
        check_val("t6_err_align", 64'(err_align), 64'd0);
        check_val("t6_err_ovrun", 64'(err_ovrun), 64'd0);
        issue(1'b0, 20'd300);
        issue(1'b1, 20'd400);
        idle(3);
        pop_check("t6_fresh", 32'd700, 16'd2, 1'b0);

        // full credit count after reset, then an over-issue that must be dropped
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, SUM_W'(2000 + i));
            check_val("t7_issue_ok", 64'(issue_ok), (i == 7) ? 64'd0 : 64'd1);
        end
        issue(1'b1, 20'd2999);
        check_val("t7_cred_sat", 64'(issue_ok), 64'd0);
        idle(3);
        check_val("t7_ovrun", 64'(err_ovrun), 64'd1);
        for (int i = 0; i < 8; i++) begin
            pop_check("t7_drain", ACC_W'(2000 + i), 16'd1, 1'b0);
        end
        check_val("t7_empty", 64'(m_valid), 64'd0);
        check_val("t7_issue_ok_end", 64'(issue_ok), 64'd1);
        check_val("t7_ovrun_sticky", 64'(err_ovrun), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
